// File: rtl/reorder_buffer_if.sv
// Bundle between the issue/writeback/retire stages and the reorder buffer.
// "master" is the core side and "slave" is the buffer itself.
interface reorder_buffer_if #(
   parameter int DEPTH   = 32,
   parameter int ENTRY_W = $clog2(DEPTH),
   parameter int CDB_N   = 3
);
   logic                     issue_valid;
   logic [1:0]               issue_kind;
   logic [4:0]               issue_rd;
   logic                     issue_pred_taken;
   logic [ENTRY_W-1:0]       issue_entry;
   logic                     rob_full;
   logic [CDB_N-1:0]         cdb_valid;
   logic [CDB_N*ENTRY_W-1:0] cdb_entry;
   logic [CDB_N*32-1:0]      cdb_value;
   logic [CDB_N-1:0]         cdb_taken;
   logic [CDB_N*32-1:0]      cdb_target;
   logic [ENTRY_W-1:0]       qry_entry_a;
   logic [ENTRY_W-1:0]       qry_entry_b;
   logic                     qry_ready_a;
   logic                     qry_ready_b;
   logic [31:0]              qry_value_a;
   logic [31:0]              qry_value_b;
   logic                     commit_valid;
   logic [ENTRY_W-1:0]       commit_entry;
   logic [4:0]               commit_rd;
   logic [31:0]              commit_value;
   logic                     store_commit_valid;
   logic [ENTRY_W-1:0]       store_commit_entry;
   logic                     store_done;
   logic                     flush;
   logic [31:0]              flush_pc;

   modport master (
      output issue_valid, issue_kind, issue_rd, issue_pred_taken,
      output cdb_valid, cdb_entry, cdb_value, cdb_taken, cdb_target,
      output qry_entry_a, qry_entry_b, store_done,
      input  issue_entry, rob_full, qry_ready_a, qry_ready_b, qry_value_a, qry_value_b,
      input  commit_valid, commit_entry, commit_rd, commit_value,
      input  store_commit_valid, store_commit_entry, flush, flush_pc
   );

   modport slave (
      input  issue_valid, issue_kind, issue_rd, issue_pred_taken,
      input  cdb_valid, cdb_entry, cdb_value, cdb_taken, cdb_target,
      input  qry_entry_a, qry_entry_b, store_done,
      output issue_entry, rob_full, qry_ready_a, qry_ready_b, qry_value_a, qry_value_b,
      output commit_valid, commit_entry, commit_rd, commit_value,
      output store_commit_valid, store_commit_entry, flush, flush_pc
   );
endinterface

// File: rtl/reorder_buffer.sv
// In-order retirement buffer with multi-channel writeback, operand forwarding,
// store release handshake and branch/JALR redirect flush.
module reorder_buffer #(
   parameter int DEPTH   = 32,
   parameter int ENTRY_W = $clog2(DEPTH),
   parameter int CDB_N   = 3
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           rdy,
   reorder_buffer_if.slave bus
);
   localparam logic [1:0] KIND_REG    = 2'b00;
   localparam logic [1:0] KIND_STORE  = 2'b01;
   localparam logic [1:0] KIND_BRANCH = 2'b10;

   typedef enum logic {ST_RUN, ST_WAIT_ST} state_t;
   state_t r_state, w_state_next;

   logic [DEPTH-1:0]   r_busy, r_ready, r_pred, r_taken;
   logic [1:0]         r_kind   [DEPTH];
   logic [4:0]         r_rd     [DEPTH];
   logic [31:0]        r_value  [DEPTH];
   logic [31:0]        r_target [DEPTH];
   logic [ENTRY_W-1:0] r_head, r_tail;
   logic [ENTRY_W:0]   r_count;

   logic               r_commit_valid, r_store_commit_valid, r_flush;
   logic [ENTRY_W-1:0] r_commit_entry, r_store_commit_entry;
   logic [4:0]         r_commit_rd;
   logic [31:0]        r_commit_value, r_flush_pc;

   logic [ENTRY_W-1:0] w_cdb_entry  [CDB_N];
   logic [31:0]        w_cdb_value  [CDB_N];
   logic [31:0]        w_cdb_target [CDB_N];
   logic [CDB_N-1:0]   w_hit_a, w_hit_b;
   logic               w_full, w_head_live, w_retire, w_commit, w_store_rel, w_flush_take, w_issue;

   generate
      for (genvar gi = 0; gi < CDB_N; gi++) begin : g_cdb
         assign w_cdb_entry[gi]  = bus.cdb_entry[gi*ENTRY_W +: ENTRY_W];
         assign w_cdb_value[gi]  = bus.cdb_value[gi*32 +: 32];
         assign w_cdb_target[gi] = bus.cdb_target[gi*32 +: 32];
         assign w_hit_a[gi]      = bus.cdb_valid[gi] && (w_cdb_entry[gi] == bus.qry_entry_a);
         assign w_hit_b[gi]      = bus.cdb_valid[gi] && (w_cdb_entry[gi] == bus.qry_entry_b);
      end
   endgenerate

   assign w_full      = (r_count == (ENTRY_W+1)'(DEPTH));
   assign w_head_live = r_busy[r_head] && r_ready[r_head];

   // Retirement decision; everything is gated by rdy so a stalled core sees no pulses.
   always_comb begin
      w_state_next = r_state;
      w_retire     = 1'b0;
      w_commit     = 1'b0;
      w_store_rel  = 1'b0;
      w_flush_take = 1'b0;
      if (rdy) begin
         case (r_state)
            ST_RUN: begin
               if (w_head_live) begin
                  case (r_kind[r_head])
                     KIND_REG: begin
                        w_retire = 1'b1;
                        w_commit = 1'b1;
                     end
                     KIND_STORE: begin
                        w_store_rel  = 1'b1;
                        w_state_next = ST_WAIT_ST;
                     end
                     KIND_BRANCH: begin
                        if (r_taken[r_head] != r_pred[r_head]) w_flush_take = 1'b1;
                        else                                   w_retire     = 1'b1;
                     end
                     default: begin
                        w_flush_take = 1'b1;
                        w_commit     = 1'b1;
                     end
                  endcase
               end
            end
            ST_WAIT_ST: begin
               if (bus.store_done) begin
                  w_retire     = 1'b1;
                  w_state_next = ST_RUN;
               end
            end
            default: w_state_next = ST_RUN;
         endcase
      end
   end

   assign w_issue = rdy && bus.issue_valid && !w_full && !w_flush_take;

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_RUN;
      else     r_state <= w_state_next;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_busy  <= '0;
         r_ready <= '0;
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else if (rdy) begin
         // Descending walk so the lowest-index channel lands last and wins on a tag clash.
         for (int i = CDB_N-1; i >= 0; i--) begin
            if (bus.cdb_valid[i] && r_busy[w_cdb_entry[i]]) begin
               r_ready[w_cdb_entry[i]]  <= 1'b1;
               r_value[w_cdb_entry[i]]  <= w_cdb_value[i];
               r_taken[w_cdb_entry[i]]  <= bus.cdb_taken[i];
               r_target[w_cdb_entry[i]] <= w_cdb_target[i];
            end
         end
         if (w_issue) begin
            r_busy[r_tail]  <= 1'b1;
            r_ready[r_tail] <= 1'b0;
            r_kind[r_tail]  <= bus.issue_kind;
            r_rd[r_tail]    <= bus.issue_rd;
            r_pred[r_tail]  <= bus.issue_pred_taken;
            r_tail          <= r_tail + ENTRY_W'(1);
         end
         if (w_retire) begin
            r_busy[r_head] <= 1'b0;
            r_head         <= r_head + ENTRY_W'(1);
         end
         r_count <= r_count + (ENTRY_W+1)'(w_issue) - (ENTRY_W+1)'(w_retire);
         if (w_flush_take) begin
            r_busy  <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_commit_valid       <= 1'b0;
         r_commit_entry       <= '0;
         r_commit_rd          <= '0;
         r_commit_value       <= '0;
         r_store_commit_valid <= 1'b0;
         r_store_commit_entry <= '0;
         r_flush              <= 1'b0;
         r_flush_pc           <= '0;
      end else begin
         r_commit_valid       <= w_commit;
         r_store_commit_valid <= w_store_rel;
         r_flush              <= w_flush_take;
         if (w_commit) begin
            r_commit_entry <= r_head;
            r_commit_rd    <= r_rd[r_head];
            r_commit_value <= r_value[r_head];
         end
         if (w_store_rel)  r_store_commit_entry <= r_head;
         if (w_flush_take) r_flush_pc           <= r_target[r_head];
      end
   end

   // Forwarding: a same-cycle CDB hit overrides the stored value, lowest channel first.
   always_comb begin
      bus.qry_ready_a = r_ready[bus.qry_entry_a];
      bus.qry_value_a = r_value[bus.qry_entry_a];
      bus.qry_ready_b = r_ready[bus.qry_entry_b];
      bus.qry_value_b = r_value[bus.qry_entry_b];
      for (int i = CDB_N-1; i >= 0; i--) begin
         if (w_hit_a[i]) begin
            bus.qry_ready_a = 1'b1;
            bus.qry_value_a = w_cdb_value[i];
         end
         if (w_hit_b[i]) begin
            bus.qry_ready_b = 1'b1;
            bus.qry_value_b = w_cdb_value[i];
         end
      end
   end

   assign bus.issue_entry        = r_tail;
   assign bus.rob_full           = w_full;
   assign bus.commit_valid       = r_commit_valid;
   assign bus.commit_entry       = r_commit_entry;
   assign bus.commit_rd          = r_commit_rd;
   assign bus.commit_value       = r_commit_value;
   assign bus.store_commit_valid = r_store_commit_valid;
   assign bus.store_commit_entry = r_store_commit_entry;
   assign bus.flush              = r_flush;
   assign bus.flush_pc           = r_flush_pc;
endmodule
